// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: one digit per clock, LSD first, through a single bcd_adder cell.
// Optional invalid-digit flag on err when BCD_INVALID_DIGIT_CHECK_EN is defined.

module bcd_adder (
   input  logic       cin,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic [3:0] BCD0,
   output logic       BCD1
);
   logic [4:0] raw;

   assign raw  = {1'b0, A} + {1'b0, B} + {4'b0, cin};
   assign BCD1 = (raw > 5'd9);
   assign BCD0 = BCD1 ? (raw[3:0] + 4'd6) : raw[3:0];
endmodule

module bcd_serial_add_ctrl #(
   parameter int NDIGITS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 cin,
   input  logic [4*NDIGITS-1:0] A,
   input  logic [4*NDIGITS-1:0] B,
   output logic [4*NDIGITS-1:0] sum,
   output logic                 cout,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam int W  = 4 * NDIGITS;
   localparam int IW = $clog2(NDIGITS);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic            cout_q, cout_d;
   logic [3:0]      cell_a, cell_b, cell_s;
   logic            cell_c;
   logic            last;
   logic            accept;

   assign cell_a = a_q[idx_q*4 +: 4];
   assign cell_b = b_q[idx_q*4 +: 4];
   assign last   = (idx_q == IW'(NDIGITS - 1));
   assign accept = (state_q == S_IDLE) && start;

   bcd_adder u_cell (
      .cin  (carry_q),
      .A    (cell_a),
      .B    (cell_b),
      .BCD0 (cell_s),
      .BCD1 (cell_c)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               carry_d = cin;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            sum_d[idx_q*4 +: 4] = cell_s;
            carry_d             = cell_c;
            idx_d               = idx_q + 1'b1;
            if (last) begin
               cout_d  = cell_c;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign busy = (state_q == S_ADD);
   assign done = (state_q == S_DONE);

`ifdef BCD_INVALID_DIGIT_CHECK_EN
   // Flag is latched on the last ADD edge so it appears together with done.
   logic err_q;
   logic bad_digit;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (a_q[i*4 +: 4] > 4'd9 || b_q[i*4 +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        err_q <= 1'b0;
      else if (accept)                   err_q <= 1'b0;
      else if (state_q == S_ADD && last) err_q <= bad_digit;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomized self-checking bench for bcd_serial_add_ctrl against a digit-rule reference model.
module tb_bcd_serial_add_ctrl;
   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk, rst_n, start, cin;
   logic [W-1:0] A, B, sum;
   logic         cout, busy, done, err;

   int vectors = 0;
   int miscompares = 0;

`ifdef BCD_INVALID_DIGIT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   bcd_serial_add_ctrl #(.NDIGITS(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cin(cin), .A(A), .B(B),
      .sum(sum), .cout(cout), .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: each digit raw = a+b+carry; raw>9 gives (raw+6) mod 16 with carry 1.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [W-1:0] s;
      int cy, raw;
      s  = '0;
      cy = int'(c);
      for (int i = 0; i < N; i++) begin
         raw = int'(a[i*4 +: 4]) + int'(b[i*4 +: 4]) + cy;
         if (raw > 9) begin s[i*4 +: 4] = 4'((raw + 6) % 16); cy = 1; end
         else         begin s[i*4 +: 4] = 4'(raw);            cy = 0; end
      end
      return {cy[0], s};
   endfunction

   function automatic logic has_bad(input logic [W-1:0] a, input logic [W-1:0] b);
      for (int i = 0; i < N; i++)
         if (a[i*4 +: 4] > 9 || b[i*4 +: 4] > 9) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < N; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   // Drives one operation from an IDLE cycle; scrambles inputs after capture.
   // Returns observations from the DONE cycle and from the IDLE cycle after it.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output int lat, output int bcnt, output logic ovl,
                         output logic [W-1:0] s, output logic co, output logic er,
                         output logic done_after, output logic er_after);
      int edges;
      edges = 0; lat = 0; bcnt = 0; ovl = 1'b0; s = '0; co = 1'b0; er = 1'b0;
      A = a; B = b; cin = c; start = 1'b1;
      while (lat == 0 && edges < 40) begin
         @(posedge clk); #1;
         edges++;
         start = 1'b0;
         A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
         if (busy) bcnt++;
         if (busy && done) ovl = 1'b1;
         if (done) begin lat = edges; s = sum; co = cout; er = err; end
      end
      @(posedge clk); #1;
      done_after = done;
      er_after   = err;
   endtask

   task automatic test_reset();
      #3;
      vectors++;
      if ({sum, cout, busy, done, err} !== '0) begin
         miscompares++;
         $display("FAIL reset_async: got sum=%h cout=%b busy=%b done=%b err=%b, want all 0", sum, cout, busy, done, err);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({sum, cout, busy, done, err} !== '0) begin
         miscompares++;
         $display("FAIL reset_idle: got sum=%h cout=%b busy=%b done=%b err=%b, want all 0", sum, cout, busy, done, err);
      end
   endtask

   task automatic test_nominal();
      int lat, bcnt; logic ovl, co, er, da, ea; logic [W-1:0] s, hold_s;
      run_op(16'h1234, 16'h5678, 1'b0, lat, bcnt, ovl, s, co, er, da, ea);
      vectors++;
      if (s !== 16'h6912 || co !== 1'b0) begin
         miscompares++; $display("FAIL nominal_sum: got %h/%b want 6912/0", s, co);
      end
      vectors++;
      if (lat != N + 1 || bcnt != N || ovl !== 1'b0 || da !== 1'b0) begin
         miscompares++;
         $display("FAIL nominal_timing: got lat=%0d busy=%0d ovl=%b done_after=%b want %0d/%0d/0/0", lat, bcnt, ovl, da, N + 1, N);
      end
      hold_s = s;
      repeat (3) begin
         A = W'($urandom); B = W'($urandom); cin = 1'($urandom);
         @(posedge clk); #1;
         vectors++;
         if (sum !== hold_s || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold: got sum=%h cout=%b busy=%b done=%b want %h/0/0/0", sum, cout, busy, done, hold_s);
         end
      end
   endtask

   task automatic test_ripple();
      int lat, bcnt; logic ovl, co, er, da, ea; logic [W-1:0] s;
      run_op(16'h9999, 16'h0001, 1'b0, lat, bcnt, ovl, s, co, er, da, ea);
      vectors++;
      if (s !== 16'h0000 || co !== 1'b1) begin
         miscompares++; $display("FAIL ripple_9999: got %h/%b want 0000/1", s, co);
      end
      run_op(16'h0000, 16'h0000, 1'b1, lat, bcnt, ovl, s, co, er, da, ea);
      vectors++;
      if (s !== 16'h0001 || co !== 1'b0) begin
         miscompares++; $display("FAIL ripple_cin: got %h/%b want 0001/0", s, co);
      end
   endtask

   task automatic test_random();
      int lat, bcnt; logic ovl, co, er, da, ea; logic [W-1:0] s, a, b; logic c;
      logic [W:0] exp;
      for (int k = 0; k < 25; k++) begin
         if (k % 5 == 4) begin a = W'($urandom); b = W'($urandom); end
         else begin a = rand_bcd(); b = rand_bcd(); end
         c = 1'($urandom);
         exp = ref_add(a, b, c);
         run_op(a, b, c, lat, bcnt, ovl, s, co, er, da, ea);
         vectors++;
         if ({co, s} !== exp || lat != N + 1 || er !== (CHK & has_bad(a, b))) begin
            miscompares++;
            $display("FAIL random_op: %h+%h+%b got %b/%h lat=%0d err=%b want %b/%h lat=%0d err=%b",
                     a, b, c, co, s, lat, er, exp[W], exp[W-1:0], N + 1, CHK & has_bad(a, b));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] oa [0:40];
      logic [W-1:0] ob [0:40];
      logic         oc [0:40];
      logic [W:0]   exp;
      logic         exp_done;
      int           pulses;
      pulses = 0;
      for (int e = 1; e <= 3 * (N + 2); e++) begin
         oa[e] = rand_bcd(); ob[e] = rand_bcd(); oc[e] = 1'($urandom);
         A = oa[e]; B = ob[e]; cin = oc[e]; start = 1'b1;
         @(posedge clk); #1;
         exp_done = ((e - 1) % (N + 2) == N);
         vectors++;
         if (done !== exp_done || (busy && done)) begin
            miscompares++; $display("FAIL b2b_done: edge %0d got done=%b busy=%b want done=%b", e, done, busy, exp_done);
         end
         if (exp_done) begin
            pulses++;
            exp = ref_add(oa[e-N], ob[e-N], oc[e-N]);
            vectors++;
            if ({cout, sum} !== exp) begin
               miscompares++; $display("FAIL b2b_sum: edge %0d got %b/%h want %b/%h", e, cout, sum, exp[W], exp[W-1:0]);
            end
         end
      end
      start = 1'b0;
      vectors++;
      if (pulses != 3) begin
         miscompares++; $display("FAIL b2b_pulses: got %0d want 3", pulses);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt, bad; logic ovl, co, er, da, ea; logic [W-1:0] s, a, b;
      a = rand_bcd(); b = rand_bcd();
      a[3:0] = 4'd5; b[3:0] = 4'd4;
      A = a; B = b; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({sum, cout, busy, done, err} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid: got sum=%h cout=%b busy=%b done=%b err=%b want all 0", sum, cout, busy, done, err);
      end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 0;
      repeat (N + 3) begin
         @(posedge clk); #1;
         if (done || busy) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL reset_no_done: got %0d busy/done cycles want 0", bad);
      end
      run_op(16'h0050, 16'h0050, 1'b0, lat, bcnt, ovl, s, co, er, da, ea);
      vectors++;
      if (s !== 16'h0100 || co !== 1'b0 || lat != N + 1) begin
         miscompares++; $display("FAIL reset_restart: got %h/%b lat=%0d want 0100/0 lat=%0d", s, co, lat, N + 1);
      end
   endtask

   task automatic test_invalid();
      int lat, bcnt; logic ovl, co, er, da, ea; logic [W-1:0] s;
      run_op(16'h00A0, 16'h0000, 1'b0, lat, bcnt, ovl, s, co, er, da, ea);
      vectors++;
      if (s !== 16'h0100 || co !== 1'b0) begin
         miscompares++; $display("FAIL invalid_sum: got %h/%b want 0100/0", s, co);
      end
      vectors++;
      if (er !== CHK || ea !== CHK) begin
         miscompares++; $display("FAIL invalid_err: got done=%b idle=%b want %b", er, ea, CHK);
      end
      run_op(16'h0011, 16'h0022, 1'b0, lat, bcnt, ovl, s, co, er, da, ea);
      vectors++;
      if (er !== 1'b0 || s !== 16'h0033) begin
         miscompares++; $display("FAIL invalid_clear: got err=%b sum=%h want 0/0033", er, s);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; cin = 1'b0; A = '0; B = '0;
      test_reset();
      test_nominal();
      test_ripple();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_invalid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
